prime_shift_unit_p: RTL and testbench

- Parametrised successor of the lab3 prime/non-prime digit unit.
- Each accepted W-bit number is classified as prime or non-prime and checked against the requested category (selection).
- On a match: the number is registered with its neighbour prime (prev/next) or its shifted value (right/left), and one of four per-operation wrap counters is bumped.
- On a mismatch: a warning is raised and a saturating error counter is bumped.
- Sits between the switch-input stage and the 7-segment display driver.

---
 rtl/prime_shift_pkg.sv | 51 +++++
 rtl/prime_lut_p.sv | 30 +++
 rtl/prime_shift_unit_p.sv | 134 +++++++++++++
 tb/tb_prime_shift_unit_p.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/prime_shift_pkg.sv
// Shared encodings and elaboration-time prime helpers for the prime/shift unit.
package prime_shift_pkg;

  localparam logic SEL_PRIME       = 1'b0;
  localparam logic SEL_NONPRIME    = 1'b1;
  localparam logic MODE_PREV_RIGHT = 1'b0;
  localparam logic MODE_NEXT_LEFT  = 1'b1;

  // Trial division; only ever evaluated at elaboration to build the lookup tables.
  function automatic bit is_prime(input int n);
    bit r;
    r = (n >= 2);
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) r = 1'b0;
    end
    return r;
  endfunction

  // Largest prime below 2^w.
  function automatic int max_prime(input int w);
    int r;
    r = 2;
    for (int m = 2; m < (1 << w); m++) begin
      if (is_prime(m)) r = m;
    end
    return r;
  endfunction

  // Largest prime strictly below n; wraps to the largest W-bit prime.
  function automatic int prev_prime(input int n, input int w);
    int r;
    r = 0;
    for (int m = 2; m < n; m++) begin
      if (is_prime(m)) r = m;
    end
    if (r == 0) r = max_prime(w);
    return r;
  endfunction

  // Smallest prime strictly above n within W bits; wraps to 2.
  function automatic int next_prime(input int n, input int w);
    int r;
    r = 0;
    for (int m = (1 << w) - 1; m > n; m--) begin
      if (is_prime(m)) r = m;
    end
    if (r == 0) r = 2;
    return r;
  endfunction

endpackage

// File: rtl/prime_lut_p.sv
// Combinational primality / neighbour-prime lookup over every W-bit value.
module prime_lut_p
  import prime_shift_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_number,
  output logic         o_is_prime,
  output logic [W-1:0] o_prev,
  output logic [W-1:0] o_next
);

  localparam int unsigned N = 1 << W;

  logic [N-1:0] w_prime_tab;
  logic [W-1:0] w_prev_tab [N];
  logic [W-1:0] w_next_tab [N];

  // Constant tables, one entry per possible operand.
  for (genvar g = 0; g < N; g++) begin : g_tab
    assign w_prime_tab[g] = is_prime(g) ? 1'b1 : 1'b0;
    assign w_prev_tab[g]  = W'(prev_prime(g, int'(W)));
    assign w_next_tab[g]  = W'(next_prime(g, int'(W)));
  end

  assign o_is_prime = w_prime_tab[i_number];
  assign o_prev     = w_prev_tab[i_number];
  assign o_next     = w_next_tab[i_number];

endmodule

// File: rtl/prime_shift_unit_p.sv
// Classifies each accepted number, applies the requested prime/shift op and keeps
// per-op wrap counters plus a saturating mismatch counter.
module prime_shift_unit_p
  import prime_shift_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned CNT_MOD = 10,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [W-1:0]     number,
  input  logic             selection,
  input  logic             mode,
  output logic [W-1:0]     digit0,
  output logic [W-1:0]     digit1,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1,
  output logic             warning,
  output logic             out_valid,
  output logic [CNT_W-1:0] err_count
);

  function automatic logic [CNT_W-1:0] inc_mod(input logic [CNT_W-1:0] v);
    if (int'(v) + 1 >= int'(CNT_MOD)) return '0;
    return v + CNT_W'(1);
  endfunction

  logic             w_is_prime;
  logic [W-1:0]     w_prev, w_next;
  logic             w_match;

  logic [W-1:0]     r_digit0, r_digit1, w_digit0_d, w_digit1_d;
  logic [CNT_W-1:0] r_count0, r_count1, w_count0_d, w_count1_d;
  logic [CNT_W-1:0] r_pp, r_pn, r_nr, r_nl, w_pp_d, w_pn_d, w_nr_d, w_nl_d;
  logic [CNT_W-1:0] r_err, w_err_d;
  logic             r_warning, w_warning_d;
  logic             r_out_valid, w_out_valid_d;

  prime_lut_p #(
    .W(W)
  ) u_lut (
    .i_number  (number),
    .o_is_prime(w_is_prime),
    .o_prev    (w_prev),
    .o_next    (w_next)
  );

  // Next-state: execute the matching op or flag the mismatch; idle holds everything.
  always_comb begin
    w_match       = (w_is_prime == (selection == SEL_PRIME));
    w_digit0_d    = r_digit0;
    w_digit1_d    = r_digit1;
    w_count0_d    = r_count0;
    w_count1_d    = r_count1;
    w_pp_d        = r_pp;
    w_pn_d        = r_pn;
    w_nr_d        = r_nr;
    w_nl_d        = r_nl;
    w_err_d       = r_err;
    w_warning_d   = r_warning;
    w_out_valid_d = 1'b0;
    if (in_valid) begin
      if (w_match) begin
        w_warning_d   = 1'b0;
        w_out_valid_d = 1'b1;
        w_digit0_d    = number;
        if (selection == SEL_PRIME) begin
          if (mode == MODE_PREV_RIGHT) begin
            w_digit1_d = w_prev;
            w_pp_d     = inc_mod(r_pp);
          end else begin
            w_digit1_d = w_next;
            w_pn_d     = inc_mod(r_pn);
          end
          w_count0_d = w_pp_d;
          w_count1_d = w_pn_d;
        end else begin
          if (mode == MODE_PREV_RIGHT) begin
            w_digit1_d = number >> 1;
            w_nr_d     = inc_mod(r_nr);
          end else begin
            w_digit1_d = {number[W-2:0], 1'b0};
            w_nl_d     = inc_mod(r_nl);
          end
          w_count0_d = w_nr_d;
          w_count1_d = w_nl_d;
        end
      end else begin
        w_warning_d = 1'b1;
        if (r_err != '1) w_err_d = r_err + CNT_W'(1);
      end
    end
  end

  // State registers; clear wins over any sample in the same cycle.
  always_ff @(posedge CLK) begin
    if (clear) begin
      r_digit0    <= '0;
      r_digit1    <= '0;
      r_count0    <= '0;
      r_count1    <= '0;
      r_pp        <= '0;
      r_pn        <= '0;
      r_nr        <= '0;
      r_nl        <= '0;
      r_err       <= '0;
      r_warning   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_digit0    <= w_digit0_d;
      r_digit1    <= w_digit1_d;
      r_count0    <= w_count0_d;
      r_count1    <= w_count1_d;
      r_pp        <= w_pp_d;
      r_pn        <= w_pn_d;
      r_nr        <= w_nr_d;
      r_nl        <= w_nl_d;
      r_err       <= w_err_d;
      r_warning   <= w_warning_d;
      r_out_valid <= w_out_valid_d;
    end
  end

  assign digit0    = r_digit0;
  assign digit1    = r_digit1;
  assign count0    = r_count0;
  assign count1    = r_count1;
  assign warning   = r_warning;
  assign out_valid = r_out_valid;
  assign err_count = r_err;

endmodule

// File: tb/tb_prime_shift_unit_p.sv
// Table-driven bench for prime_shift_unit_p: instance A (W=4, CNT_MOD=10, CNT_W=8)
// and instance B (W=6, CNT_MOD=4, CNT_W=3).
module tb_prime_shift_unit_p;

  typedef struct {
    string    name;
    bit       clr;
    bit       vld;
    int       num;
    bit       sel;
    bit       mode;
    int       d0;
    int       d1;
    int       c0;
    int       c1;
    bit       warn;
    bit       ov;
    int       err;
  } vec_t;

  logic CLK;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instance A signals
  logic       a_clear, a_valid, a_sel, a_mode;
  logic [3:0] a_number, a_digit0, a_digit1;
  logic [7:0] a_count0, a_count1, a_err;
  logic       a_warning, a_out_valid;

  // Instance B signals
  logic       b_clear, b_valid, b_sel, b_mode;
  logic [5:0] b_number, b_digit0, b_digit1;
  logic [2:0] b_count0, b_count1, b_err;
  logic       b_warning, b_out_valid;

  prime_shift_unit_p #(
    .W(4), .CNT_MOD(10), .CNT_W(8)
  ) u_dut_a (
    .CLK      (CLK),
    .clear    (a_clear),
    .in_valid (a_valid),
    .number   (a_number),
    .selection(a_sel),
    .mode     (a_mode),
    .digit0   (a_digit0),
    .digit1   (a_digit1),
    .count0   (a_count0),
    .count1   (a_count1),
    .warning  (a_warning),
    .out_valid(a_out_valid),
    .err_count(a_err)
  );

  prime_shift_unit_p #(
    .W(6), .CNT_MOD(4), .CNT_W(3)
  ) u_dut_b (
    .CLK      (CLK),
    .clear    (b_clear),
    .in_valid (b_valid),
    .number   (b_number),
    .selection(b_sel),
    .mode     (b_mode),
    .digit0   (b_digit0),
    .digit1   (b_digit1),
    .count0   (b_count0),
    .count1   (b_count1),
    .warning  (b_warning),
    .out_valid(b_out_valid),
    .err_count(b_err)
  );

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t sb[$];
  vec_t tab_a[$];
  vec_t tab_b[$];

  function automatic vec_t mk(string nm, bit clr, bit vld, int num, bit sel, bit mode,
                              int d0, int d1, int c0, int c1, bit w, bit ov, int err);
    vec_t v;
    v.name = nm; v.clr = clr; v.vld = vld; v.num = num; v.sel = sel; v.mode = mode;
    v.d0 = d0; v.d1 = d1; v.c0 = c0; v.c1 = c1; v.warn = w; v.ov = ov; v.err = err;
    return v;
  endfunction

  task automatic chk(string nm, string field, logic [31:0] act, int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, field, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, then compare just after the edge.
  task automatic run_vec(int inst, vec_t v);
    vec_t e;
    if (inst == 0) begin
      a_clear = v.clr; a_valid = v.vld; a_number = 4'(v.num); a_sel = v.sel; a_mode = v.mode;
    end else begin
      b_clear = v.clr; b_valid = v.vld; b_number = 6'(v.num); b_sel = v.sel; b_mode = v.mode;
    end
    sb.push_back(v);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    if (inst == 0) begin
      chk(e.name, "digit0",    32'(a_digit0),    e.d0);
      chk(e.name, "digit1",    32'(a_digit1),    e.d1);
      chk(e.name, "count0",    32'(a_count0),    e.c0);
      chk(e.name, "count1",    32'(a_count1),    e.c1);
      chk(e.name, "warning",   32'(a_warning),   int'(e.warn));
      chk(e.name, "out_valid", 32'(a_out_valid), int'(e.ov));
      chk(e.name, "err_count", 32'(a_err),       e.err);
    end else begin
      chk(e.name, "digit0",    32'(b_digit0),    e.d0);
      chk(e.name, "digit1",    32'(b_digit1),    e.d1);
      chk(e.name, "count0",    32'(b_count0),    e.c0);
      chk(e.name, "count1",    32'(b_count1),    e.c1);
      chk(e.name, "warning",   32'(b_warning),   int'(e.warn));
      chk(e.name, "out_valid", 32'(b_out_valid), int'(e.ov));
      chk(e.name, "err_count", 32'(b_err),       e.err);
    end
  endtask

  initial begin
    a_clear = 1'b1; a_valid = 1'b0; a_number = '0; a_sel = 1'b0; a_mode = 1'b0;
    b_clear = 1'b1; b_valid = 1'b0; b_number = '0; b_sel = 1'b0; b_mode = 1'b0;

    //            name       clr vld num sel mode  d0  d1  c0 c1 w ov err
    tab_a.push_back(mk("rst",     1, 0,  0, 0, 0,   0,  0, 0, 0, 0, 0, 0));
    tab_a.push_back(mk("idle1",   0, 0,  5, 0, 0,   0,  0, 0, 0, 0, 0, 0));
    tab_a.push_back(mk("idle2",   0, 0,  5, 0, 0,   0,  0, 0, 0, 0, 0, 0));
    tab_a.push_back(mk("idle3",   0, 0,  5, 0, 0,   0,  0, 0, 0, 0, 0, 0));
    tab_a.push_back(mk("p7prev",  0, 1,  7, 0, 0,   7,  5, 1, 0, 0, 1, 0));
    tab_a.push_back(mk("p13next", 0, 1, 13, 0, 1,  13,  2, 1, 1, 0, 1, 0));
    tab_a.push_back(mk("p2prev",  0, 1,  2, 0, 0,   2, 13, 2, 1, 0, 1, 0));
    tab_a.push_back(mk("hold",    0, 0,  9, 1, 1,   2, 13, 2, 1, 0, 0, 0));
    tab_a.push_back(mk("mis4",    0, 1,  4, 0, 0,   2, 13, 2, 1, 1, 0, 1));
    tab_a.push_back(mk("warnhold",0, 0,  4, 0, 0,   2, 13, 2, 1, 1, 0, 1));
    tab_a.push_back(mk("p3next",  0, 1,  3, 0, 1,   3,  5, 2, 2, 0, 1, 1));
    tab_a.push_back(mk("n15left", 0, 1, 15, 1, 1,  15, 14, 0, 1, 0, 1, 1));
    tab_a.push_back(mk("n9right", 0, 1,  9, 1, 0,   9,  4, 1, 1, 0, 1, 1));
    tab_a.push_back(mk("n0right", 0, 1,  0, 1, 0,   0,  0, 2, 1, 0, 1, 1));
    tab_a.push_back(mk("p11prev", 0, 1, 11, 0, 0,  11,  7, 3, 2, 0, 1, 1));
    tab_a.push_back(mk("mis5",    0, 1,  5, 1, 0,  11,  7, 3, 2, 1, 0, 2));
    tab_a.push_back(mk("mis1",    0, 1,  1, 0, 1,  11,  7, 3, 2, 1, 0, 3));
    tab_a.push_back(mk("n12left", 0, 1, 12, 1, 1,  12,  8, 2, 2, 0, 1, 3));
    tab_a.push_back(mk("n8left",  0, 1,  8, 1, 1,   8,  0, 2, 3, 0, 1, 3));
    tab_a.push_back(mk("clrmid",  1, 1,  3, 0, 0,   0,  0, 0, 0, 0, 0, 0));

    tab_b.push_back(mk("b_rst",    1, 0,  0, 0, 0,   0,  0, 0, 0, 0, 0, 0));
    tab_b.push_back(mk("b_p61next",0, 1, 61, 0, 1,  61,  2, 0, 1, 0, 1, 0));
    tab_b.push_back(mk("b_p2prev", 0, 1,  2, 0, 0,   2, 61, 1, 1, 0, 1, 0));

    b_clear = 1'b0;
    for (int i = 0; i < tab_a.size(); i++) run_vec(0, tab_a[i]);

    // Wrap: pn counts 1..9 then 0; pp stays cleared.
    for (int i = 0; i < 10; i++) begin
      run_vec(0, mk($sformatf("wrap%0d", i), 0, 1, 5, 0, 1, 5, 7, 0, (i + 1) % 10, 0, 1, 0));
    end
    run_vec(0, mk("wrap_pp", 0, 1, 5, 0, 0, 5, 3, 1, 0, 0, 1, 0));
    a_valid = 1'b0; a_clear = 1'b0;

    for (int i = 0; i < tab_b.size(); i++) run_vec(1, tab_b[i]);

    // CNT_MOD=4 wrap on the W=6 instance: pn 2,3,0,1.
    for (int i = 0; i < 4; i++) begin
      run_vec(1, mk($sformatf("b_wrap%0d", i), 0, 1, 61, 0, 1, 61, 2, 1, (i + 2) % 4, 0, 1, 0));
    end
    // Error counter saturates at 7 with CNT_W=3.
    for (int i = 0; i < 9; i++) begin
      run_vec(1, mk($sformatf("b_sat%0d", i), 0, 1, 4, 0, 0, 61, 2, 1, 1, 1, 0,
                    (i + 1 > 7) ? 7 : i + 1));
    end
    run_vec(1, mk("b_n63left", 0, 1, 63, 1, 1, 63, 62, 0, 1, 0, 1, 7));
    run_vec(1, mk("b_clrmid",  1, 1,  3, 0, 0,  0,  0, 0, 0, 0, 0, 0));
    run_vec(1, mk("b_idle",    0, 0,  3, 0, 0,  0,  0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
